// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters and the register-file write arbiter.
// master = requester side, slave = arbiter side.
interface regfile_write_arbiter_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            req0_valid;
    logic            req0_ready;
    logic [AW-1:0]   req0_rd_addr;
    logic [XLEN-1:0] req0_rd_data;
    logic            req1_valid;
    logic            req1_ready;
    logic [AW-1:0]   req1_rd_addr;
    logic [XLEN-1:0] req1_rd_data;
    logic            reg_write;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;

    modport master (
        output req0_valid, req0_rd_addr, req0_rd_data,
        output req1_valid, req1_rd_addr, req1_rd_data,
        input  req0_ready, req1_ready,
        input  reg_write, rd_addr, rd_data
    );

    modport slave (
        input  req0_valid, req0_rd_addr, req0_rd_data,
        input  req1_valid, req1_rd_addr, req1_rd_data,
        output req0_ready, req1_ready,
        output reg_write, rd_addr, rd_data
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a registered write-out stage.
// Define RF_SCOREBOARD_EN to build the per-register busy scoreboard.
module regfile_write_arbiter #(
    parameter int  XLEN = 64,
    parameter int  NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  wr,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rd,
    input  logic [AW-1:0]           rs1_addr,
    input  logic [AW-1:0]           rs2_addr,
    output logic                    rs1_busy,
    output logic                    rs2_busy
);
    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } prio_t;

    prio_t           prio_reg, prio_next;
    logic            grant0, grant1;
    logic            reg_write_reg;
    logic [AW-1:0]   rd_addr_reg;
    logic [XLEN-1:0] rd_data_reg;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg <= PRIO_REQ0;
        end else begin
            prio_reg <= prio_next;
        end
    end

    // The loser of every grant takes priority next, so contention alternates.
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        prio_next = prio_reg;
        if (!rst) begin
            if (wr.req0_valid && (!wr.req1_valid || prio_reg == PRIO_REQ0)) begin
                grant0 = 1'b1;
            end else if (wr.req1_valid) begin
                grant1 = 1'b1;
            end
        end
        if (grant0) begin
            prio_next = PRIO_REQ1;
        end else if (grant1) begin
            prio_next = PRIO_REQ0;
        end
    end

    assign wr.req0_ready = grant0;
    assign wr.req1_ready = grant1;

    assign sel_addr = grant1 ? wr.req1_rd_addr : wr.req0_rd_addr;
    assign sel_data = grant1 ? wr.req1_rd_data : wr.req0_rd_data;

    // Writes to x0 complete the handshake but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_reg <= 1'b0;
            rd_addr_reg   <= '0;
            rd_data_reg   <= '0;
        end else if (grant0 || grant1) begin
            reg_write_reg <= (sel_addr != '0);
            rd_addr_reg   <= sel_addr;
            rd_data_reg   <= sel_data;
        end else begin
            reg_write_reg <= 1'b0;
        end
    end

    assign wr.reg_write = reg_write_reg;
    assign wr.rd_addr   = rd_addr_reg;
    assign wr.rd_data   = rd_data_reg;

`ifdef RF_SCOREBOARD_EN
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;

    // A new issue to the same register overrides the clear from a committing write.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
        if (gi == 0) begin : g_x0
            assign busy_next[gi] = 1'b0;
        end else begin : g_reg
            assign busy_next[gi] = (issue_valid && issue_rd == AW'(gi)) ||
                                   (busy_reg[gi] && !(reg_write_reg && rd_addr_reg == AW'(gi)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign rs1_busy = busy_reg[rs1_addr];
    assign rs2_busy = busy_reg[rs2_addr];
`else
    logic unused_scoreboard_inputs;
    assign unused_scoreboard_inputs = ^{issue_valid, issue_rd, rs1_addr, rs2_addr};
    assign rs1_busy = 1'b0;
    assign rs2_busy = 1'b0;
`endif
endmodule
